vc_ram_queue_1w1r: RTL and testbench



---
 rtl/vc_queue_pkg.sv | 26 ++
 rtl/vc_ram_queue_1w1r_if.sv | 26 ++
 rtl/vc_ram_queue_1w1r_ram.sv | 25 ++
 rtl/vc_ram_queue_1w1r.sv | 133 +++++++++++++
 tb/tb_vc_ram_queue_1w1r.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/vc_queue_pkg.sv
// Shared helpers for the val/rdy RAM-backed queue family: occupancy-counter
// width rule, pointer increment with explicit wrap, and the handshake fire rule.
package vc_queue_pkg;

    // An occupancy counter must hold 0..ENTRIES, hence one bit wider than a pointer.
    function automatic int unsigned cnt_sz(input int unsigned addr_sz);
        return addr_sz + 32'd1;
    endfunction

    // Advance a pointer, wrapping ENTRIES-1 -> 0 by compare so non-power-of-two depths work.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned entries);
        logic [31:0] nxt_s;
        if (ptr == (entries - 32'd1)) begin
            nxt_s = 32'd0;
        end else begin
            nxt_s = ptr + 32'd1;
        end
        return nxt_s;
    endfunction

    // A transfer happens only when both sides agree in the same cycle.
    function automatic logic fire(input logic val, input logic rdy);
        return val & rdy;
    endfunction

endpackage

// File: rtl/vc_ram_queue_1w1r_if.sv
// Enqueue/dequeue val/rdy bundle for vc_ram_queue_1w1r.
// master = producer/consumer environment, slave = the queue itself.
interface vc_ram_queue_1w1r_if #(
    parameter int DATA_SZ = 32,
    parameter int ADDR_SZ = 3
);
    localparam int CNT_SZ = vc_queue_pkg::cnt_sz(ADDR_SZ);

    logic               enq_val;
    logic               enq_rdy;
    logic [DATA_SZ-1:0] enq_bits;
    logic               deq_val;
    logic               deq_rdy;
    logic [DATA_SZ-1:0] deq_bits;
    logic [CNT_SZ-1:0]  count;

    modport master (
        output enq_val, enq_bits, deq_rdy,
        input  enq_rdy, deq_val, deq_bits, count
    );

    modport slave (
        input  enq_val, enq_bits, deq_rdy,
        output enq_rdy, deq_val, deq_bits, count
    );
endinterface

// File: rtl/vc_ram_queue_1w1r_ram.sv
// 1-write/1-read flip-flop RAM: synchronous write, combinational read.
// Contents are deliberately not reset; the queue never reads an unwritten slot.
module vc_ram_queue_1w1r_ram #(
    parameter int DATA_SZ = 32,
    parameter int ENTRIES = 8,
    parameter int ADDR_SZ = 3
) (
    input  logic               clk,
    input  logic               wen_p,
    input  logic [ADDR_SZ-1:0] waddr_p,
    input  logic [DATA_SZ-1:0] wdata_p,
    input  logic [ADDR_SZ-1:0] raddr,
    output logic [DATA_SZ-1:0] rdata
);
    logic [DATA_SZ-1:0] mem_q [ENTRIES];

    // Store the write data into the addressed slot at the rising edge.
    always_ff @(posedge clk) begin
        if (wen_p) begin
            mem_q[waddr_p] <= wdata_p;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/vc_ram_queue_1w1r.sv
// Circular-buffer FIFO controller driving a 1w1r flip-flop RAM.
// Optional macro VC_QUEUE_BYPASS_EN: when empty, enq data is presented on deq
// combinationally and passes straight through if the consumer is ready.
module vc_ram_queue_1w1r
    import vc_queue_pkg::*;
#(
    parameter int DATA_SZ = 32,
    parameter int ENTRIES = 8,
    parameter int ADDR_SZ = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vc_ram_queue_1w1r_if.slave   q
);
    localparam int CNT_SZ = cnt_sz(ADDR_SZ);
    localparam logic [CNT_SZ-1:0] ENTRIES_C = CNT_SZ'(ENTRIES);

    logic [ADDR_SZ-1:0] wptr_q, wptr_d;
    logic [ADDR_SZ-1:0] rptr_q, rptr_d;
    logic [CNT_SZ-1:0]  count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;

    logic               enq_rdy_s;
    logic               deq_val_s;
    logic [DATA_SZ-1:0] deq_bits_s;
    logic [DATA_SZ-1:0] rdata_s;
    logic               enq_fire_s;
    logic               deq_fire_s;
    logic               pass_s;
    logic               wen_s;
    logic               rd_adv_s;

    vc_ram_queue_1w1r_ram #(
        .DATA_SZ (DATA_SZ),
        .ENTRIES (ENTRIES),
        .ADDR_SZ (ADDR_SZ)
    ) u_ram (
        .clk     (clk),
        .wen_p   (wen_s),
        .waddr_p (wptr_q),
        .wdata_p (q.enq_bits),
        .raddr   (rptr_q),
        .rdata   (rdata_s)
    );

    // Handshake: ready/valid from registered flags, fire terms, and RAM write/read advance.
    always_comb begin
        enq_rdy_s  = !full_q;
        pass_s     = 1'b0;
`ifdef VC_QUEUE_BYPASS_EN
        if (empty_q && q.enq_val) begin
            deq_val_s  = 1'b1;
            deq_bits_s = q.enq_bits;
            pass_s     = q.deq_rdy;
        end else begin
            deq_val_s  = !empty_q;
            deq_bits_s = rdata_s;
        end
`else
        deq_val_s  = !empty_q;
        deq_bits_s = rdata_s;
`endif
        enq_fire_s = fire(q.enq_val, enq_rdy_s);
        deq_fire_s = fire(deq_val_s, q.deq_rdy);
        // A pass-through transfer never touches the RAM or the pointers.
        wen_s      = enq_fire_s & !pass_s;
        rd_adv_s   = deq_fire_s & !pass_s;
    end

    // Next-state for pointers, occupancy and the derived full/empty flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wen_s) begin
            wptr_d = ADDR_SZ'(ptr_inc(32'(wptr_q), ENTRIES));
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_adv_s) begin
            rptr_d = ADDR_SZ'(ptr_inc(32'(rptr_q), ENTRIES));
        end else begin
            rptr_d = rptr_q;
        end
        case ({wen_s, rd_adv_s})
            2'b10:   count_d = count_q + {{(CNT_SZ-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_SZ-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        full_d  = (count_d == ENTRIES_C);
        empty_d = (count_d == {CNT_SZ{1'b0}});
    end

    // State registers; reset empties the queue immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= {ADDR_SZ{1'b0}};
            rptr_q  <= {ADDR_SZ{1'b0}};
            count_q <= {CNT_SZ{1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign q.enq_rdy  = enq_rdy_s;
    assign q.deq_val  = deq_val_s;
    assign q.deq_bits = deq_bits_s;
    assign q.count    = count_q;

`ifndef SYNTHESIS
    // Report impossible occupancy, pointer/count disagreement and undersized pointers.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (count_q > ENTRIES_C) begin
                $display("RTL-ERROR: count %0d exceeds ENTRIES %0d", count_q, ENTRIES);
            end
            if ((wptr_q == rptr_q) != ((count_q == {CNT_SZ{1'b0}}) || (count_q == ENTRIES_C))) begin
                $display("RTL-ERROR: wptr %0d rptr %0d inconsistent with count %0d", wptr_q, rptr_q, count_q);
            end
            if ((1 << ADDR_SZ) < ENTRIES) begin
                $display("RTL-ERROR: ADDR_SZ %0d too small for ENTRIES %0d", ADDR_SZ, ENTRIES);
            end
        end
    end
`endif
endmodule

// File: tb/tb_vc_ram_queue_1w1r.sv
// Bench for vc_ram_queue_1w1r: an 8-deep and a 5-deep queue driven with the
// same inputs, each compared against a queue-based reference model.
module tb_vc_ram_queue_1w1r;
    import vc_queue_pkg::*;

`ifdef VC_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic        ev;
    logic        dr;
    logic [31:0] eb;

    vc_ram_queue_1w1r_if #(.DATA_SZ(32), .ADDR_SZ(3)) if8 ();
    vc_ram_queue_1w1r_if #(.DATA_SZ(32), .ADDR_SZ(3)) if5 ();

    assign if8.enq_val  = ev;
    assign if8.enq_bits = eb;
    assign if8.deq_rdy  = dr;
    assign if5.enq_val  = ev;
    assign if5.enq_bits = eb;
    assign if5.deq_rdy  = dr;

    vc_ram_queue_1w1r #(.DATA_SZ(32), .ENTRIES(8), .ADDR_SZ(3)) u_q8 (
        .clk(clk), .reset_n(reset_n), .q(if8.slave)
    );
    vc_ram_queue_1w1r #(.DATA_SZ(32), .ENTRIES(5), .ADDR_SZ(3)) u_q5 (
        .clk(clk), .reset_n(reset_n), .q(if5.slave)
    );

    // Reference model: plain FIFO contents per queue and its capacity.
    logic [31:0] mq [2][$];
    int          cap [2] = '{8, 5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int k, input logic rdy, input logic val,
                           input logic [31:0] bits, input logic [3:0] cnt);
        int    sz;
        string nm;
        logic  exp_val;
        sz      = mq[k].size();
        nm      = (k == 0) ? "q8" : "q5";
        exp_val = (sz > 0) || (BYP && ev);
        chk({nm, ".enq_rdy"}, 32'(rdy), 32'(sz < cap[k]));
        chk({nm, ".deq_val"}, 32'(val), 32'(exp_val));
        chk({nm, ".count"},   32'(cnt), 32'(sz));
        if (exp_val) begin
            chk({nm, ".deq_bits"}, bits, (sz > 0) ? mq[k][0] : eb);
        end
    endtask

    task automatic model_edge(input int k);
        int sz;
        sz = mq[k].size();
        if (BYP && sz == 0 && ev && dr) return;
        if (dr && sz > 0) void'(mq[k].pop_front());
        if (ev && sz < cap[k]) mq[k].push_back(eb);
    endtask

    // One cycle: drive inputs, check outputs before the edge, advance the models.
    task automatic step(input logic v, input logic [31:0] b, input logic r);
        ev = v; eb = b; dr = r;
        #1;
        chk_dut(0, if8.enq_rdy, if8.deq_val, if8.deq_bits, if8.count);
        chk_dut(1, if5.enq_rdy, if5.deq_val, if5.deq_bits, if5.count);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    initial begin
        ev = 1'b0; eb = 32'd0; dr = 1'b0; reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, then a single enqueue visible one cycle later.
        step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'hA5A5_0001, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1);

        // Fill past capacity, then dequeue while full with enq_val held high.
        for (int i = 1; i <= 9; i++) step(1'b1, 32'(i), 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b1);
        repeat (9) step(1'b0, 32'd0, 1'b1);

        // Empty queue with enq and deq both asserted (latency / bypass behaviour).
        step(1'b1, 32'h0000_003C, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);

        // Wrap at occupancy 3, then 10 cycles of simultaneous traffic at occupancy 4.
        for (int i = 0; i < 3; i++) step(1'b1, 32'(100 + i), 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 32'(200 + i), 1'b1);
        step(1'b1, 32'd300, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b1);
        repeat (9) step(1'b0, 32'd0, 1'b1);

        // Random traffic: an enqueue-heavy phase then a dequeue-heavy phase.
        for (int i = 0; i < 250; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0);
        for (int i = 0; i < 250; i++)
            step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0);

        // Asynchronous reset between edges with 5 entries stored.
        repeat (9) step(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'(400 + i), 1'b0);
        ev = 1'b0; dr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("q8.rst_enq_rdy", 32'(if8.enq_rdy), 32'd1);
        chk("q8.rst_deq_val", 32'(if8.deq_val), 32'd0);
        chk("q8.rst_count",   32'(if8.count),   32'd0);
        chk("q5.rst_enq_rdy", 32'(if5.enq_rdy), 32'd1);
        chk("q5.rst_deq_val", 32'(if5.deq_val), 32'd0);
        chk("q5.rst_count",   32'(if5.count),   32'd0);
        mq[0].delete();
        mq[1].delete();
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'h0000_0077, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
